ycbcr_frame_ctrl: RTL and testbench

//  Frame-level sequencer placed in front of the RGB->YCbCr converter. Gates the camera sync strobes
//  (vsync/href/clken) so the converter only sees whole frames, latches enable/mode configuration at

---
 rtl/ycbcr_pkg.sv | 26 ++
 rtl/ycbcr_frame_ctrl_sync_edge_det.sv | 23 ++
 rtl/ycbcr_frame_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ycbcr_frame_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ycbcr_pkg.sv
// Shared constants for the YCbCr frame sequencer.
// Holds FSM state codes, converter mode codes and the mode sanitiser.
package ycbcr_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FRAME = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [1:0] MODE_YCBCR = 2'd0;
  localparam logic [1:0] MODE_Y     = 2'd1;
  localparam logic [1:0] MODE_RGB   = 2'd2;

  localparam int CNT_W_DEF = 12;

  // The reserved code falls back to full YCbCr conversion.
  function automatic logic [1:0] mode_sanitize(input logic [1:0] m);
    logic [1:0] r;
    case (m)
      MODE_Y:   r = MODE_Y;
      MODE_RGB: r = MODE_RGB;
      default:  r = MODE_YCBCR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ycbcr_frame_ctrl_sync_edge_det.sv
// One-register edge detector for camera strobes.
// Reset value is a parameter so an already-high input gives no rise after reset.
module sync_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_d <= RST_VAL;
    else        r_d <= i_d;
  end

  assign o_rise = i_d & ~r_d;
  assign o_fall = ~i_d & r_d;

endmodule

// File: rtl/ycbcr_frame_ctrl.sv
// Frame sequencer in front of the RGB->YCbCr converter: gates sync strobes
// to whole frames, shadows the mode per frame and checks frame geometry.
module ycbcr_frame_ctrl
  import ycbcr_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int LAT       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_enable,
  input  logic [1:0]       cfg_mode,
  input  logic             err_clr,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  output logic             cvt_frame_vsync,
  output logic             cvt_frame_href,
  output logic             cvt_frame_clken,
  output logic [1:0]       active_mode,
  output logic             busy,
  output logic             frame_start,
  output logic             frame_done,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic [15:0]      frame_cnt,
  output logic             err_hsize,
  output logic             err_vsize,
  output logic             err_overrun
);

  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] HD = CNT_W'(IMG_HDISP);
  localparam logic [CNT_W-1:0] VD = CNT_W'(IMG_VDISP);
  localparam logic [DW-1:0] DLAST = DW'(LAT - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [DW-1:0]    r_dcnt;
  logic [CNT_W-1:0] r_pix_x;
  logic [CNT_W-1:0] r_pix_y;
  logic [CNT_W-1:0] w_x_base;
  logic [CNT_W-1:0] w_x_inc;
  logic [CNT_W-1:0] w_y_inc;
  logic [15:0]      r_fcnt;
  logic [1:0]       r_mode;
  logic             r_cvt_vs;
  logic             r_cvt_hr;
  logic             r_cvt_ck;
  logic             r_fstart;
  logic             r_fdone;
  logic             r_err_h;
  logic             r_err_v;
  logic             r_err_o;
  logic             w_vs_rise;
  logic             w_vs_fall;
  logic             w_hr_rise;
  logic             w_hr_fall;
  logic             w_start;
  logic             w_last;
  logic             w_in_frame;
  logic             w_fwd;
  logic             w_herr;
  logic             w_verr;
  logic             w_oerr;

  // vsync detector resets high: a frame in progress at reset release is skipped.
  sync_edge_det #(.RST_VAL(1'b1)) u_vs_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (per_frame_vsync),
    .o_rise (w_vs_rise),
    .o_fall (w_vs_fall)
  );

  sync_edge_det #(.RST_VAL(1'b0)) u_hr_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (per_frame_href),
    .o_rise (w_hr_rise),
    .o_fall (w_hr_fall)
  );

  assign w_in_frame = (r_state == FRAME);
  assign w_start = (r_state == IDLE) & w_vs_rise & cfg_enable;
  assign w_last = (r_state == DRAIN) & (r_dcnt == DLAST);

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (r_state == IDLE):  if (w_start)   w_next = FRAME;
      (r_state == FRAME): if (w_vs_fall) w_next = DRAIN;
      (r_state == DRAIN): if (w_last)    w_next = IDLE;
      default:                           w_next = IDLE;
    endcase
  end

  assign w_fwd = (w_next == FRAME);
  assign w_x_base = w_hr_rise ? '0 : r_pix_x;

  always_comb begin
    w_x_inc = w_x_base;
    if (per_frame_clken && per_frame_href && w_x_base != CNT_MAX)
      w_x_inc = w_x_base + 1'b1;
  end

  always_comb begin
    w_y_inc = r_pix_y;
    if (w_hr_fall && r_pix_y != CNT_MAX)
      w_y_inc = r_pix_y + 1'b1;
  end

  assign w_herr = w_in_frame & w_hr_fall & (w_x_inc != HD);
  assign w_verr = w_in_frame & w_vs_fall & (w_y_inc != VD);
  assign w_oerr = (r_state == DRAIN) & w_vs_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_dcnt   <= '0;
      r_pix_x  <= '0;
      r_pix_y  <= '0;
      r_fcnt   <= '0;
      r_mode   <= MODE_YCBCR;
      r_cvt_vs <= 1'b0;
      r_cvt_hr <= 1'b0;
      r_cvt_ck <= 1'b0;
      r_fstart <= 1'b0;
      r_fdone  <= 1'b0;
      r_err_h  <= 1'b0;
      r_err_v  <= 1'b0;
      r_err_o  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_dcnt   <= (r_state == DRAIN) ? r_dcnt + 1'b1 : '0;
      r_cvt_vs <= per_frame_vsync & w_fwd;
      r_cvt_hr <= per_frame_href & w_fwd;
      r_cvt_ck <= per_frame_clken & w_fwd;
      r_fstart <= w_start;
      r_fdone  <= w_last;
      r_err_h  <= (r_err_h & ~err_clr) | w_herr;
      r_err_v  <= (r_err_v & ~err_clr) | w_verr;
      r_err_o  <= (r_err_o & ~err_clr) | w_oerr;
      if (w_last) r_fcnt <= r_fcnt + 16'd1;
      if (w_start) begin
        r_mode  <= mode_sanitize(cfg_mode);
        r_pix_x <= '0;
        r_pix_y <= '0;
      end else if (w_in_frame) begin
        r_pix_x <= w_hr_fall ? '0 : w_x_inc;
        r_pix_y <= w_y_inc;
      end
    end
  end

  assign cvt_frame_vsync = r_cvt_vs;
  assign cvt_frame_href  = r_cvt_hr;
  assign cvt_frame_clken = r_cvt_ck;
  assign active_mode     = r_mode;
  assign busy            = (r_state != IDLE);
  assign frame_start     = r_fstart;
  assign frame_done      = r_fdone;
  assign pix_x           = r_pix_x;
  assign pix_y           = r_pix_y;
  assign frame_cnt       = r_fcnt;
  assign err_hsize       = r_err_h;
  assign err_vsize       = r_err_v;
  assign err_overrun     = r_err_o;

endmodule

// File: tb/tb_ycbcr_frame_ctrl.sv
// Directed bench for ycbcr_frame_ctrl on an 8x4 frame with LAT=3.
// Gated strobes are checked through an expected-value queue every cycle.
module tb_ycbcr_frame_ctrl;

  localparam int HD  = 8;
  localparam int VD  = 4;
  localparam int LAT = 3;
  localparam int CW  = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_enable;
  logic [1:0]    cfg_mode;
  logic          err_clr;
  logic          per_frame_vsync;
  logic          per_frame_href;
  logic          per_frame_clken;
  logic          cvt_frame_vsync;
  logic          cvt_frame_href;
  logic          cvt_frame_clken;
  logic [1:0]    active_mode;
  logic          busy;
  logic          frame_start;
  logic          frame_done;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic [15:0]   frame_cnt;
  logic          err_hsize;
  logic          err_vsize;
  logic          err_overrun;

  always #5 clk = ~clk;

  ycbcr_frame_ctrl #(
    .IMG_HDISP (HD),
    .IMG_VDISP (VD),
    .CNT_W     (CW),
    .LAT       (LAT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_enable      (cfg_enable),
    .cfg_mode        (cfg_mode),
    .err_clr         (err_clr),
    .per_frame_vsync (per_frame_vsync),
    .per_frame_href  (per_frame_href),
    .per_frame_clken (per_frame_clken),
    .cvt_frame_vsync (cvt_frame_vsync),
    .cvt_frame_href  (cvt_frame_href),
    .cvt_frame_clken (cvt_frame_clken),
    .active_mode     (active_mode),
    .busy            (busy),
    .frame_start     (frame_start),
    .frame_done      (frame_done),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .frame_cnt       (frame_cnt),
    .err_hsize       (err_hsize),
    .err_vsize       (err_vsize),
    .err_overrun     (err_overrun)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  int         exp_cnt = 0;
  bit         fwd = 1'b0;
  logic [2:0] sbq[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {13'd0, cvt_frame_vsync, cvt_frame_href, cvt_frame_clken,
            active_mode, busy, frame_start, frame_done, pix_x, pix_y,
            frame_cnt, err_hsize, err_vsize, err_overrun};
  endfunction

  task automatic step(input logic vs, input logic hr, input logic ck);
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ck;
    sbq.push_back(fwd ? {vs, hr, ck} : 3'b000);
    @(posedge clk);
    #1;
    chk("cvt_strobes", {cvt_frame_vsync, cvt_frame_href, cvt_frame_clken},
        sbq.pop_front());
  endtask

  task automatic put_line(input int len);
    for (int p = 0; p < len; p++) step(1, 1, 1);
    step(1, 0, 0);
    step(1, 0, 0);
  endtask

  task automatic body(input int nl, input int bad, input int blen);
    for (int l = 0; l < nl; l++) put_line((l == bad) ? blen : HD);
  endtask

  task automatic frame(input int nl, input int bad, input int blen,
                       input bit f);
    fwd = f;
    step(1, 0, 0);
    chk("frame_start", frame_start, f);
    step(1, 0, 0);
    chk("frame_start_pulse", frame_start, 0);
    body(nl, bad, blen);
    step(0, 0, 0);
    fwd = 1'b0;
  endtask

  task automatic drain(input logic [1:0] mode);
    int k = 0;
    for (int i = 1; i <= 10 && k == 0; i++) begin
      step(0, 0, 0);
      if (frame_done) k = i;
      else begin
        chk("drain_mode", active_mode, mode);
        chk("drain_busy", busy, 1);
      end
    end
    exp_cnt++;
    chk("done_latency", k, LAT);
    step(0, 0, 0);
    chk("done_pulse", frame_done, 0);
    chk("busy_idle", busy, 0);
    chk("frame_cnt", frame_cnt, exp_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_enable = 1'b0;
    cfg_mode = 2'd0;
    err_clr = 1'b0;
    per_frame_vsync = 1'b0;
    per_frame_href = 1'b0;
    per_frame_clken = 1'b0;
    #1;
    chk("reset_outputs", all_out(), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);

    // clean frame
    cfg_enable = 1'b1;
    cfg_mode = 2'd0;
    frame(VD, -1, 0, 1);
    chk("pix_y_end", pix_y, VD);
    chk("busy_frame", busy, 1);
    drain(2'd0);
    chk("clean_errs", {err_hsize, err_vsize, err_overrun}, 0);

    // enable raised after vsync rise: frame dropped
    fwd = 1'b0;
    cfg_enable = 1'b0;
    step(1, 0, 0);
    chk("late_en_start", frame_start, 0);
    cfg_enable = 1'b1;
    body(VD, -1, 0);
    step(0, 0, 0);
    repeat (4) step(0, 0, 0);
    chk("late_en_busy", busy, 0);
    chk("late_en_cnt", frame_cnt, exp_cnt);
    frame(VD, -1, 0, 1);
    drain(2'd0);

    // mode shadowing
    cfg_mode = 2'd2;
    fwd = 1'b1;
    step(1, 0, 0);
    chk("mode_latch_rgb", active_mode, 2);
    cfg_mode = 2'd1;
    step(1, 0, 0);
    body(VD, -1, 0);
    step(0, 0, 0);
    fwd = 1'b0;
    chk("mode_held", active_mode, 2);
    drain(2'd2);

    // mode 1, enable dropped mid-frame
    fwd = 1'b1;
    step(1, 0, 0);
    chk("mode_latch_y", active_mode, 1);
    body(2, -1, 0);
    cfg_enable = 1'b0;
    body(2, -1, 0);
    step(0, 0, 0);
    fwd = 1'b0;
    drain(2'd1);
    frame(VD, -1, 0, 0);
    repeat (4) step(0, 0, 0);
    chk("dis_cnt", frame_cnt, exp_cnt);
    chk("dis_busy", busy, 0);
    cfg_enable = 1'b1;
    cfg_mode = 2'd3;
    frame(VD, -1, 0, 1);
    chk("mode_reserved", active_mode, 0);
    drain(2'd0);

    // short line, then long frame
    cfg_mode = 2'd0;
    fwd = 1'b1;
    step(1, 0, 0);
    step(1, 0, 0);
    body(2, -1, 0);
    chk("hsize_before", err_hsize, 0);
    put_line(HD - 1);
    chk("hsize_set", err_hsize, 1);
    body(1, -1, 0);
    step(0, 0, 0);
    fwd = 1'b0;
    chk("vsize_ok", err_vsize, 0);
    drain(2'd0);
    chk("hsize_sticky", err_hsize, 1);
    frame(VD + 1, -1, 0, 1);
    chk("vsize_set", err_vsize, 1);
    drain(2'd0);
    err_clr = 1'b1;
    step(0, 0, 0);
    err_clr = 1'b0;
    chk("clr_errs", {err_hsize, err_vsize}, 0);

    // clear coincident with new errors
    fwd = 1'b1;
    step(1, 0, 0);
    step(1, 0, 0);
    for (int p = 0; p < HD - 1; p++) step(1, 1, 1);
    err_clr = 1'b1;
    step(1, 0, 0);
    err_clr = 1'b0;
    chk("hsize_clr_coinc", err_hsize, 1);
    step(1, 0, 0);
    body(VD, -1, 0);
    err_clr = 1'b1;
    step(0, 0, 0);
    err_clr = 1'b0;
    fwd = 1'b0;
    chk("vsize_clr_coinc", err_vsize, 1);
    chk("hsize_cleared", err_hsize, 0);
    drain(2'd0);
    err_clr = 1'b1;
    step(0, 0, 0);
    err_clr = 1'b0;

    // vsync re-rise during drain
    frame(VD, -1, 0, 1);
    step(1, 0, 0);
    chk("overrun_set", err_overrun, 1);
    body(VD, -1, 0);
    step(0, 0, 0);
    repeat (4) step(0, 0, 0);
    exp_cnt++;
    chk("overrun_cnt", frame_cnt, exp_cnt);
    chk("overrun_busy", busy, 0);

    // async reset mid-line
    fwd = 1'b1;
    step(1, 0, 0);
    step(1, 0, 0);
    for (int p = 0; p < 3; p++) step(1, 1, 1);
    chk("pix_x_mid", pix_x, 3);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_line", all_out(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fwd = 1'b0;
    exp_cnt = 0;
    for (int p = 0; p < HD - 3; p++) step(1, 1, 1);
    step(1, 0, 0);
    chk("post_rst_start", frame_start, 0);
    step(1, 0, 0);
    body(VD - 1, -1, 0);
    step(0, 0, 0);
    chk("post_rst_busy", busy, 0);
    step(0, 0, 0);
    frame(VD, -1, 0, 1);
    drain(2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
